// File: rtl/program_loader.sv
// Framed byte-stream bootloader: assembles 16-bit words (high byte first) and writes
// them to instruction memory, releasing the CPU once a frame completes. Optional
// trailing XOR checksum byte enabled by `define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] MAX_WORDS = 8'd128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        im_wr_en,
    output logic [7:0]  im_wr_addr,
    output logic [15:0] im_wr_data,
    output logic        cpu_run,
    output logic        load_done,
    output logic        load_err,
    output logic [7:0]  words_loaded
);

    typedef enum logic [2:0] {IDLE, LEN, HI, LO, CHK, RUN, ERR} state_t;

    state_t     state, state_nx;
    logic [7:0] count;
    logic [7:0] hi_byte;
    logic       accept;
    logic       len_bad;
    logic       is_last;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    // reload wins over any byte offered in the same cycle
    assign accept  = in_valid && in_ready && !reload;
    assign len_bad = (in_data == 8'd0) || (in_data > MAX_WORDS);
    assign is_last = (words_loaded + 8'd1) == count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        state_nx = state;
        if (reload) begin
            state_nx = IDLE;
        end else if (accept) begin
            case (state)
                IDLE:    if (in_data == SYNC_BYTE) state_nx = LEN;
                LEN:     state_nx = len_bad ? ERR : HI;
                HI:      state_nx = LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                LO:      state_nx = is_last ? CHK : HI;
                CHK:     state_nx = (in_data == checksum) ? RUN : ERR;
`else
                LO:      state_nx = is_last ? RUN : HI;
`endif
                ERR:     if (in_data == SYNC_BYTE) state_nx = LEN;
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        in_ready = (state != RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_wr_en     <= 1'b0;
            im_wr_addr   <= 8'h00;
            im_wr_data   <= 16'h0000;
            cpu_run      <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= 8'h00;
            count        <= 8'h00;
            hi_byte      <= 8'h00;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum     <= 8'h00;
`endif
        end else begin
            im_wr_en <= 1'b0;
            if (reload) begin
                cpu_run      <= 1'b0;
                load_done    <= 1'b0;
                load_err     <= 1'b0;
                words_loaded <= 8'h00;
            end else if (accept) begin
                case (state)
                    LEN: begin
                        if (len_bad) begin
                            load_err <= 1'b1;
                        end else begin
                            count        <= in_data;
                            words_loaded <= 8'h00;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            checksum     <= 8'h00;
`endif
                        end
                    end
                    HI: begin
                        hi_byte  <= in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        checksum <= checksum ^ in_data;
`endif
                    end
                    LO: begin
                        im_wr_en     <= 1'b1;
                        im_wr_data   <= {hi_byte, in_data};
                        im_wr_addr   <= {words_loaded[6:0], 1'b0};
                        words_loaded <= words_loaded + 8'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        checksum     <= checksum ^ in_data;
`else
                        if (is_last) begin
                            load_done <= 1'b1;
                            cpu_run   <= 1'b1;
                        end
`endif
                    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    CHK: begin
                        if (in_data == checksum) begin
                            load_done <= 1'b1;
                            cpu_run   <= 1'b1;
                        end else begin
                            load_err  <= 1'b1;
                        end
                    end
`endif
                    ERR: if (in_data == SYNC_BYTE) load_err <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as frames are driven
// and popped by a monitor on each write strobe. Follows PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        reload;
    logic        im_wr_en;
    logic [7:0]  im_wr_addr;
    logic [15:0] im_wr_data;
    logic        cpu_run;
    logic        load_done;
    logic        load_err;
    logic [7:0]  words_loaded;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        run;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] words[128];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reload       (reload),
        .im_wr_en     (im_wr_en),
        .im_wr_addr   (im_wr_addr),
        .im_wr_data   (im_wr_data),
        .cpu_run      (cpu_run),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (reset === 1'b1 && im_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {im_wr_addr, im_wr_data}, 32'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", im_wr_addr, e.addr);
                check("wr_data", im_wr_data, e.data);
                check("wr_run", cpu_run, e.run);
                check("wr_count", words_loaded, {24'd0, e.addr} / 2 + 1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) check("ready_timeout", in_ready, 1);
        @(posedge clk);
    endtask

    task automatic go_idle(input int cycles);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        in_valid = 1'b0;
        reload   = 1'b1;
        @(negedge clk);
        reload   = 1'b0;
    endtask

    // Sends SYNC, N, N words from words[] and (when enabled) the checksum byte.
    task automatic send_frame(input int n, input bit gap, input bit bad_chk);
        logic [7:0] chk;
        wr_t        e;
        chk = 8'h00;
        for (int i = 0; i < n; i++) begin
            e.addr = 8'(2 * i);
            e.data = words[i];
            e.run  = !CHK_EN && (i == n - 1);
            exp_q.push_back(e);
            chk = chk ^ words[i][15:8] ^ words[i][7:0];
        end
        send_byte(8'hA5);
        if (gap) go_idle(0);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            if (gap) go_idle(0);
            send_byte(words[i][15:8]);
            if (gap) go_idle(0);
            send_byte(words[i][7:0]);
        end
        if (CHK_EN) begin
            if (gap) go_idle(0);
            send_byte(bad_chk ? 8'h00 : chk);
        end
        go_idle(2);
    endtask

    task automatic check_loaded(input string tag, input logic [7:0] n);
        check({tag, "_done"}, load_done, 1);
        check({tag, "_run"}, cpu_run, 1);
        check({tag, "_err"}, load_err, 0);
        check({tag, "_words"}, words_loaded, n);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        reset    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        reload   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", im_wr_en, 0);
        check("rst_outs", {im_wr_addr, im_wr_data}, 0);
        check("rst_flags", {cpu_run, load_done, load_err}, 0);
        check("rst_words", words_loaded, 0);
        check("rst_ready", in_ready, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame, back to back.
        words[0] = 16'h1234;
        words[1] = 16'h5678;
        send_frame(2, 1'b0, 1'b0);
        check_loaded("good", 8'd2);

        // Reload from RUN.
        pulse_reload();
        check("reload_run", cpu_run, 0);
        check("reload_ready", in_ready, 1);
        check("reload_flags", {load_done, load_err, words_loaded}, 0);

        // Same frame with a gapped stream.
        send_frame(2, 1'b1, 1'b0);
        check_loaded("gap", 8'd2);
        pulse_reload();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Bad checksum, then a retry straight from ERR.
        words[0] = 16'hABCD;
        send_frame(1, 1'b0, 1'b1);
        check("badchk_err", load_err, 1);
        check("badchk_run", cpu_run, 0);
        check("badchk_ready", in_ready, 1);
        send_frame(1, 1'b0, 1'b0);
        check_loaded("retry", 8'd1);
`else
        words[0] = 16'hBEEF;
        send_frame(1, 1'b0, 1'b0);
        check_loaded("nochk", 8'd1);
`endif
        pulse_reload();

        // Junk then zero length.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hA5);
        send_byte(8'h00);
        go_idle(2);
        check("len0_err", load_err, 1);
        check("len0_state", {cpu_run, load_done, words_loaded}, 0);
        pulse_reload();
        check("len_clr", load_err, 0);

        // Length 129 is illegal.
        send_byte(8'hA5);
        send_byte(8'h81);
        go_idle(2);
        check("len129_err", load_err, 1);
        check("len129_run", cpu_run, 0);
        pulse_reload();

        // Largest frame: 128 words ending at 0xFE.
        for (int i = 0; i < 128; i++) words[i] = 16'($urandom);
        send_frame(128, 1'b0, 1'b0);
        check_loaded("max", 8'h80);
        pulse_reload();

        // Reset mid-frame: outputs clear at once, nothing is written afterwards.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrst_outs", {im_wr_en, im_wr_addr, im_wr_data}, 0);
        check("midrst_flags", {cpu_run, load_done, load_err, words_loaded}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_ready", in_ready, 1);
        check("midrst_words", words_loaded, 0);

        check("final_pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the flow ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream bootloader that writes a program into the CPU instruction memory; it is the writer for the memory the CPU reads.
- Receives a framed byte stream and assembles 16-bit instruction words, high byte first.
- Writes each word to consecutive even byte addresses starting at 0x00.
- Holds the CPU in reset until a valid frame completes, then releases it.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_WORDS, 128, largest legal word count (256-byte instruction space / 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte; a transfer occurs on a clk edge with in_valid & in_ready.
- reload  input  1  abort/restart request; one-cycle pulse or level.
- im_wr_en  output  1  instruction-memory write strobe, one cycle per word.
- im_wr_addr  output  8  byte address, always even.
- im_wr_data  output  16  instruction word.
- cpu_run  output  1  1 = CPU released from reset; 0 = CPU held.
- load_done  output  1  sticky; frame loaded OK.
- load_err  output  1  sticky; frame rejected.
- words_loaded  output  8  number of words written in the current frame.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - im_wr_en=0, im_wr_addr=0, im_wr_data=0.
  - cpu_run=0, load_done=0, load_err=0, words_loaded=0.
  - Internal count, checksum and high-byte registers = 0.
- in_ready is decoded from state: 1 in IDLE, LEN, HI, LO, CHK and ERR; 0 in RUN.
- States (all transitions on an accepted byte unless noted):
  - IDLE: byte == SYNC_BYTE -> LEN; any other byte is discarded.
  - LEN: N = byte.
    - N == 0 or N > MAX_WORDS -> ERR, load_err=1.
    - Otherwise store N, clear checksum and words_loaded -> HI.
  - HI: latch byte as word[15:8], XOR it into checksum -> LO.
  - LO: XOR byte into checksum. On the next edge:
    - im_wr_en=1 for exactly one cycle.
    - im_wr_data = {hi, byte}.
    - im_wr_addr = words_loaded*2 (truncated to 8 bits).
    - words_loaded increments in the same cycle as the strobe.
    - If this was word N -> CHK, else -> HI.
  - CHK:
    - byte == checksum -> RUN, load_done=1, cpu_run=1.
    - Otherwise -> ERR, load_err=1, cpu_run stays 0.
  - RUN: no bytes accepted; cpu_run=1 held until reload.
  - ERR: discard bytes. A SYNC_BYTE -> LEN and clears load_err (retry); cpu_run stays 0.
- Write latency: im_wr_en asserts on the edge after the LO byte transfer (1 cycle). Back-to-back bytes every cycle are supported; strobes are never dropped or merged.
- Address arithmetic: 8-bit. N = 128 writes 0x00..0xFE with no wrap. A word index reaching 128 cannot occur because N is bounded.
- reload (highest priority, any state):
  - Next edge: state=IDLE, cpu_run=0, load_done=0, load_err=0, words_loaded=0.
  - A byte presented in the same cycle is not accepted (in_ready is ignored for that edge).
  - An im_wr_en pending from a LO byte in the previous cycle still completes.
  - Mid-frame reload leaves memory partially written; that is permitted.
- Asserting reset mid-frame returns to the reset values immediately; no strobe is issued afterwards.
- cpu_run is registered; it never glitches and rises on the edge after the checksum byte is accepted.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined: frame carries a trailing XOR checksum byte, handled by the CHK state as above.
- Undefined:
  - There is no CHK state and no checksum byte.
  - After word N is accepted, go directly to RUN with load_done=1; cpu_run rises on the same edge as the final im_wr_en.
  - load_err is set only by an illegal N.

Test Plan:
- Good frame: bytes A5 02 12 34 56 78 08 back-to-back -> writes (0x00, 0x1234) then (0x02, 0x5678), one cycle each; then load_done=1, cpu_run=1, words_loaded=2, in_ready=0.
- Bad checksum: A5 01 AB CD 00 -> one write (0x00, 0xABCD), load_err=1, cpu_run=0. Then A5 01 AB CD 66 -> load_done=1, cpu_run=1.
- Junk and illegal length: 00 FF A5 00 -> no writes, load_err=1. Separately, A5 81 -> load_err=1 (N = 129 > 128).
- Max frame: A5 80 followed by 256 bytes plus correct checksum -> 128 writes, last at addr 0xFE; words_loaded=0x80; cpu_run=1.
- Reload and reset: reload pulse in RUN -> cpu_run=0 next edge, state IDLE, in_ready=1. Then mid-frame (after A5 02 12) reset=0 -> all outputs 0 immediately, no further im_wr_en.
- Gapped stream: in_valid toggling 1/0 each cycle across the good frame -> identical writes and result as the back-to-back case.
- Macro undefined: A5 01 BE EF -> write (0x00, 0xBEEF); cpu_run=1 on the same edge as the strobe.
